// File: rtl/counter_monitor.sv
// Passive checker for a bounded wrap-around counter stream: predicts each next
// value, acquires lock, flags deviations and keeps saturating error/wrap counts.
module counter_monitor #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int LOCK_COUNT = 4,
    parameter int MISS_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] lower_bound,
    input  logic [DATA_WIDTH-1:0] upper_bound,
    input  logic                  clear_errors,
    output logic                  locked,
    output logic                  error_pulse,
    output logic [CNT_WIDTH-1:0]  error_count,
    output logic [CNT_WIDTH-1:0]  wrap_count,
    output logic [DATA_WIDTH-1:0] expected
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [RUN_W-1:0]  LOCK_TGT = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_TGT = MISS_W'(MISS_LIMIT);

    state_t                state;
    logic [RUN_W-1:0]      run;
    logic [MISS_W-1:0]     miss_run;
    logic                  pred_reload;  // current expected came from the reload branch

    logic                  in_range;
    logic                  match;
    logic                  err_inc;
    logic                  wrap_inc;
    logic [DATA_WIDTH-1:0] next_value;

    // s+1 is only formed when s < ub, so the increment cannot overflow.
    always_comb begin
        in_range   = (sample >= lower_bound) && (sample < upper_bound);
        next_value = in_range ? sample + DATA_WIDTH'(1) : lower_bound;
        match      = (sample == expected);
        err_inc    = sample_valid && (state == LOCKED) && !match;
        wrap_inc   = sample_valid && (state == LOCKED) && match && pred_reload;
    end

    // NOTE: all state lives in one clocked block with non-blocking assignments,
    // so every register sees the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SEARCH;
            run         <= '0;
            miss_run    <= '0;
            pred_reload <= 1'b0;
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
            wrap_count  <= '0;
            expected    <= '0;
        end else begin
            error_pulse <= err_inc;

            // Clear has priority over a coincident increment.
            if (clear_errors)
                error_count <= '0;
            else if (err_inc && error_count != '1)
                error_count <= error_count + CNT_WIDTH'(1);

            if (clear_errors)
                wrap_count <= '0;
            else if (wrap_inc && wrap_count != '1)
                wrap_count <= wrap_count + CNT_WIDTH'(1);

            if (sample_valid) begin
                // Re-seed from the observed value so one glitch costs one error.
                expected    <= next_value;
                pred_reload <= !in_range;

                case (state)
                    SEARCH: begin
                        run   <= '0;
                        state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        if (!match) begin
                            run <= '0;
                        end else if (run + RUN_W'(1) == LOCK_TGT) begin
                            run    <= '0;
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            run <= run + RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_run <= '0;
                        end else if (miss_run + MISS_W'(1) == MISS_TGT) begin
                            miss_run <= '0;
                            state    <= SEARCH;
                            locked   <= 1'b0;
                        end else begin
                            miss_run <= miss_run + MISS_W'(1);
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor (CNT_WIDTH=2 to reach saturation quickly).
module tb_counter_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [31:0] sample;
    logic [31:0] lower_bound;
    logic [31:0] upper_bound;
    logic        clear_errors;
    logic        locked;
    logic        error_pulse;
    logic [1:0]  error_count;
    logic [1:0]  wrap_count;
    logic [31:0] expected;

    int n_checks = 0;
    int n_fail   = 0;

    counter_monitor #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (2),
        .LOCK_COUNT(4),
        .MISS_LIMIT(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .sample      (sample),
        .lower_bound (lower_bound),
        .upper_bound (upper_bound),
        .clear_errors(clear_errors),
        .locked      (locked),
        .error_pulse (error_pulse),
        .error_count (error_count),
        .wrap_count  (wrap_count),
        .expected    (expected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of stimulus and return #1 after the capturing edge.
    task automatic step(input logic v, input logic [31:0] s, input logic clr);
        sample_valid = v;
        sample       = s;
        clear_errors = clr;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clear_errors = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        lower_bound  = 32'd3;
        upper_bound  = 32'd6;
        clear_errors = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", {31'd0, locked}, 0);
        check("rst_pulse", {31'd0, error_pulse}, 0);
        check("rst_err", {30'd0, error_count}, 0);
        check("rst_expected", expected, 0);
        rst = 1'b0;

        // Lock acquisition
        step(1, 3, 0);
        check("acq_seed_expected", expected, 4);
        check("acq_seed_locked", {31'd0, locked}, 0);
        step(1, 4, 0);
        step(1, 5, 0);
        step(1, 6, 0);
        check("acq_4th_locked", {31'd0, locked}, 0);
        check("acq_4th_expected", expected, 3);
        step(1, 3, 0);
        check("acq_5th_locked", {31'd0, locked}, 1);
        check("acq_5th_wrap", {30'd0, wrap_count}, 0);
        step(1, 4, 0);
        step(1, 5, 0);
        step(1, 6, 0);
        check("acq_8th_wrap", {30'd0, wrap_count}, 0);
        step(1, 3, 0);
        check("acq_9th_wrap", {30'd0, wrap_count}, 1);
        check("acq_9th_err", {30'd0, error_count}, 0);

        // Single glitch
        step(1, 4, 0);
        step(1, 5, 0);
        check("glitch_pre_pulse", {31'd0, error_pulse}, 0);
        step(1, 9, 0);
        check("glitch_pulse", {31'd0, error_pulse}, 1);
        check("glitch_expected", expected, 3);
        check("glitch_err", {30'd0, error_count}, 1);
        check("glitch_locked", {31'd0, locked}, 1);
        step(1, 3, 0);
        check("glitch_after_pulse", {31'd0, error_pulse}, 0);
        check("glitch_after_wrap", {30'd0, wrap_count}, 2);
        step(1, 4, 0);
        check("glitch_after_err", {30'd0, error_count}, 1);

        // Clear during a valid gap, then loss of lock
        step(0, 77, 1);
        check("clr_err", {30'd0, error_count}, 0);
        check("clr_wrap", {30'd0, wrap_count}, 0);
        check("gap_expected_held", expected, 5);
        step(1, 0, 0);
        check("loss1_pulse", {31'd0, error_pulse}, 1);
        check("loss1_locked", {31'd0, locked}, 1);
        step(1, 0, 0);
        check("loss2_pulse", {31'd0, error_pulse}, 1);
        check("loss2_err", {30'd0, error_count}, 2);
        step(1, 0, 0);
        check("loss3_pulse", {31'd0, error_pulse}, 1);
        check("loss3_err", {30'd0, error_count}, 3);
        check("loss3_locked", {31'd0, locked}, 0);
        step(1, 3, 0);
        check("search_no_pulse", {31'd0, error_pulse}, 0);
        step(1, 4, 0);
        step(1, 5, 0);
        step(1, 6, 0);
        check("relock_4th", {31'd0, locked}, 0);
        step(1, 3, 0);
        check("relock_5th", {31'd0, locked}, 1);
        check("relock_err", {30'd0, error_count}, 3);

        // Saturation: 5 non-consecutive mismatches, then clear with a 6th
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 9, 0);
            step(1, 3, 0);
        end
        step(1, 9, 0);
        check("sat_err", {30'd0, error_count}, 3);
        check("sat_wrap", {30'd0, wrap_count}, 3);
        check("sat_locked", {31'd0, locked}, 1);
        step(1, 9, 1);
        check("sat_clr_err", {30'd0, error_count}, 0);
        check("sat_clr_pulse", {31'd0, error_pulse}, 1);
        check("sat_clr_locked", {31'd0, locked}, 1);

        // Build error_count=2 while locked, then async reset between edges
        step(1, 3, 0);
        step(1, 4, 0);
        step(1, 9, 0);
        step(1, 3, 0);
        step(1, 9, 0);
        check("pre_rst_err", {30'd0, error_count}, 2);
        check("pre_rst_locked", {31'd0, locked}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_locked", {31'd0, locked}, 0);
        check("arst_err", {30'd0, error_count}, 0);
        check("arst_expected", expected, 0);
        #1;
        rst = 1'b0;
        step(0, 5, 0);
        step(0, 5, 0);
        step(0, 5, 0);
        check("gap_locked", {31'd0, locked}, 0);
        check("gap_expected", expected, 0);
        check("gap_pulse", {31'd0, error_pulse}, 0);

        // Out-of-range seed and all-ones edge
        step(1, 0, 0);
        check("oor_expected", expected, 3);
        lower_bound = 32'd0;
        upper_bound = 32'hFFFF_FFFF;
        step(1, 32'hFFFF_FFFF, 0);
        check("ones_expected", expected, 0);
        check("ones_pulse", {31'd0, error_pulse}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
